// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse front end: enables stream mode with 0xF4, then turns 3-byte movement
// packets into a clamped cursor position and button state.
module ps2_mouse_cursor #(
    parameter int CLK_HZ = 50_000_000,
    parameter int X_MAX  = 639,
    parameter int Y_MAX  = 479,
    parameter int FILT   = 8
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DAT_OE,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic [2:0] oBTN,
    output logic       oVALID,
    output logic       oINIT_DONE,
    output logic       oERR
);
    localparam int INH_CYC = CLK_HZ / 10_000;
    localparam int WDF_CYC = CLK_HZ / 500;
    localparam int WDT_CYC = CLK_HZ / 50;
    localparam int TW      = $clog2(WDT_CYC + 1);
    localparam int FW      = (FILT > 1) ? $clog2(FILT) : 1;

    localparam logic [TW-1:0] INH_LAST  = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] WDF_LAST  = TW'(WDF_CYC - 1);
    localparam logic [TW-1:0] WDT_LAST  = TW'(WDT_CYC - 1);
    localparam logic [TW-1:0] TMR_SAT   = {TW{1'b1}};
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [9:0]    X_LIM     = 10'(X_MAX);
    localparam logic [9:0]    Y_LIM     = 10'(Y_MAX);
    localparam logic [9:0]    X_RST     = 10'(X_MAX / 2);
    localparam logic [8:0]    Y_RST     = 9'(Y_MAX / 2);
    localparam logic [7:0]    CMD_EN    = 8'hF4;
    localparam logic [7:0]    ACK_BYTE  = 8'hFA;

    typedef enum logic [2:0] {
        S_INHIBIT, S_REQ, S_TX, S_TX_ACK, S_WAIT_FA, S_STREAM
    } state_t;

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    logic [1:0]    sync1_q, sync2_q, flt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          fall_s, dat_f_s, rx_on_s, rx_err_s;
    logic [9:0]    tx_frame_s;
    logic [10:0]   dx_s, dy_s, nx_s, ny_s;
    logic [9:0]    cx_s;
    logic [8:0]    cy_s;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d, rx_byte_q, rx_byte_d;
    logic          par_q, par_d, rx_vld_q, rx_vld_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    pbtn_q, pbtn_d;
    logic          xs_q, xs_d, ys_q, ys_d, xo_q, xo_d, yo_q, yo_d;
    logic [7:0]    b1_q, b1_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [2:0]    btn_q, btn_d;
    logic          valid_q, valid_d, init_q, init_d, err_q, err_d;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;

    // Two-flop synchroniser, stability filter and device clock edge history.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            flt_q      <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= {FW{1'b0}};
        end else begin
            sync1_q    <= {iPS2_DAT, iPS2_CLK};
            sync2_q    <= sync1_q;
            clk_prev_q <= flt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == flt_q[i]) begin
                    fcnt_q[i] <= {FW{1'b0}};
                end else if (fcnt_q[i] == FILT_LAST) begin
                    fcnt_q[i] <= {FW{1'b0}};
                    flt_q[i]  <= sync2_q[i];
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign fall_s     = clk_prev_q & ~flt_q[0];
    assign dat_f_s    = flt_q[1];
    assign rx_on_s    = (state_q == S_WAIT_FA) || (state_q == S_STREAM);
    assign tx_frame_s = {1'b1, odd_par(CMD_EN), CMD_EN};

    // Intermediates are 11 bits so negative results show up in bit 10.
    assign dx_s = {{2{xs_q}}, xs_q, b1_q};
    assign dy_s = {{2{ys_q}}, ys_q, rx_byte_q};
    assign nx_s = {1'b0, x_q} + dx_s;
    assign ny_s = {2'b00, y_q} - dy_s;
    assign cx_s = nx_s[10] ? 10'd0 : ((nx_s[9:0] > X_LIM) ? X_LIM : nx_s[9:0]);
    assign cy_s = ny_s[10] ? 9'd0  : ((ny_s[9:0] > Y_LIM) ? Y_LIM[8:0] : ny_s[8:0]);

    // Next-state logic: host transmit, byte receive, packet assembly, cursor update.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        par_d     = par_q;
        rx_byte_d = rx_byte_q;
        rx_vld_d  = 1'b0;
        rx_err_s  = 1'b0;
        idx_d     = idx_q;
        pbtn_d    = pbtn_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        b1_d      = b1_q;
        x_d       = x_q;
        y_d       = y_q;
        btn_d     = btn_q;
        valid_d   = 1'b0;
        init_d    = init_q;
        err_d     = 1'b0;
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;

        if (rx_on_s && fall_s) begin
            if (cnt_q == 4'd0) begin
                if (dat_f_s) begin
                    rx_err_s = 1'b1;
                end else begin
                    cnt_d = 4'd1;
                end
            end else if (cnt_q <= 4'd8) begin
                sh_d  = {dat_f_s, sh_q[7:1]};
                cnt_d = cnt_q + 4'd1;
            end else if (cnt_q == 4'd9) begin
                par_d = dat_f_s;
                cnt_d = 4'd10;
            end else begin
                cnt_d = 4'd0;
                if (dat_f_s && (odd_par(sh_q) == par_q)) begin
                    rx_byte_d = sh_q;
                    rx_vld_d  = 1'b1;
                end else begin
                    rx_err_s = 1'b1;
                end
            end
        end else if (rx_on_s && (cnt_q != 4'd0) && (tmr_q == WDF_LAST)) begin
            rx_err_s = 1'b1;
            cnt_d    = 4'd0;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (tmr_q == INH_LAST) begin
                    state_d  = S_REQ;
                    dat_oe_d = 1'b1;
                end else begin
                    state_d = S_INHIBIT;
                end
            end
            S_REQ: begin
                dat_oe_d = 1'b1;
                state_d  = S_TX;
            end
            S_TX: begin
                if (fall_s) begin
                    dat_oe_d = ~tx_frame_s[cnt_q];
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        state_d = S_TX_ACK;
                    end else begin
                        state_d = S_TX;
                    end
                end else if (tmr_q == WDT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_INHIBIT;
                end else begin
                    dat_oe_d = dat_oe_q;
                end
            end
            S_TX_ACK: begin
                if (fall_s) begin
                    if (!dat_f_s) begin
                        state_d = S_WAIT_FA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_INHIBIT;
                    end
                end else if (tmr_q == WDT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_INHIBIT;
                end else begin
                    state_d = S_TX_ACK;
                end
            end
            S_WAIT_FA: begin
                if (rx_err_s) begin
                    err_d   = 1'b1;
                    state_d = S_INHIBIT;
                end else if (rx_vld_q) begin
                    if (rx_byte_q == ACK_BYTE) begin
                        init_d  = 1'b1;
                        state_d = S_STREAM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_INHIBIT;
                    end
                end else begin
                    state_d = S_WAIT_FA;
                end
            end
            S_STREAM: begin
                if (rx_err_s) begin
                    err_d = 1'b1;
                    idx_d = 2'd0;
                end else if (rx_vld_q) begin
                    case (idx_q)
                        2'd0: begin
                            // Bit 3 is always set in a header byte; anything else is a resync drop.
                            if (rx_byte_q[3]) begin
                                pbtn_d = rx_byte_q[2:0];
                                xs_d   = rx_byte_q[4];
                                ys_d   = rx_byte_q[5];
                                xo_d   = rx_byte_q[6];
                                yo_d   = rx_byte_q[7];
                                idx_d  = 2'd1;
                            end else begin
                                idx_d = 2'd0;
                            end
                        end
                        2'd1: begin
                            b1_d  = rx_byte_q;
                            idx_d = 2'd2;
                        end
                        2'd2: begin
                            btn_d   = pbtn_q;
                            x_d     = xo_q ? x_q : cx_s;
                            y_d     = yo_q ? y_q : cy_s;
                            valid_d = 1'b1;
                            idx_d   = 2'd0;
                        end
                        default: idx_d = 2'd0;
                    endcase
                end else begin
                    idx_d = idx_q;
                end
            end
            default: state_d = S_INHIBIT;
        endcase

        // The inhibit pull itself produces a fall, so it must not restart the timer.
        if (state_d != state_q) begin
            tmr_d = {TW{1'b0}};
            cnt_d = 4'd0;
        end else if (fall_s && (state_q != S_INHIBIT)) begin
            tmr_d = {TW{1'b0}};
        end else if (tmr_q != TMR_SAT) begin
            tmr_d = tmr_q + TW'(1);
        end else begin
            tmr_d = tmr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= S_INHIBIT;
            tmr_q     <= {TW{1'b0}};
            cnt_q     <= 4'd0;
            sh_q      <= 8'd0;
            par_q     <= 1'b0;
            rx_byte_q <= 8'd0;
            rx_vld_q  <= 1'b0;
            idx_q     <= 2'd0;
            pbtn_q    <= 3'd0;
            xs_q      <= 1'b0;
            ys_q      <= 1'b0;
            xo_q      <= 1'b0;
            yo_q      <= 1'b0;
            b1_q      <= 8'd0;
            x_q       <= X_RST;
            y_q       <= Y_RST;
            btn_q     <= 3'd0;
            valid_q   <= 1'b0;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            rx_byte_q <= rx_byte_d;
            rx_vld_q  <= rx_vld_d;
            idx_q     <= idx_d;
            pbtn_q    <= pbtn_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            b1_q      <= b1_d;
            x_q       <= x_d;
            y_q       <= y_d;
            btn_q     <= btn_d;
            valid_q   <= valid_d;
            init_q    <= init_d;
            err_q     <= err_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    assign oPS2_CLK_OE = clk_oe_q;
    assign oPS2_DAT_OE = dat_oe_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oBTN        = btn_q;
    assign oVALID      = valid_q;
    assign oINIT_DONE  = init_q;
    assign oERR        = err_q;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor with a behavioural PS/2 mouse on the pads.
// CLK_HZ is scaled down so inhibit is 50 cycles, frame watchdog 1000, TX watchdog 10000.
module tb_ps2_mouse_cursor;
    localparam int CLK_HZ = 500_000;
    localparam int H      = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_clk = 1'b1;
    logic       m_dat = 1'b1;
    logic       ps2_clk, ps2_dat, clk_oe, dat_oe, vld, init_done, err;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] btn;
    int         checks = 0, failures = 0;
    int         n_valid = 0, n_err = 0, n_both = 0;

    assign ps2_clk = clk_oe ? 1'b0 : m_clk;
    assign ps2_dat = dat_oe ? 1'b0 : m_dat;

    ps2_mouse_cursor #(.CLK_HZ(CLK_HZ), .X_MAX(639), .Y_MAX(479), .FILT(8)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
        .oPS2_CLK_OE(clk_oe), .oPS2_DAT_OE(dat_oe), .oX(x), .oY(y), .oBTN(btn),
        .oVALID(vld), .oINIT_DONE(init_done), .oERR(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vld) n_valid <= n_valid + 1;
        if (err) n_err <= n_err + 1;
        if (vld && err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] fr;
        fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            m_dat = fr[i];
            cyc(H);
            m_clk = 1'b0;
            cyc(H);
            m_clk = 1'b1;
        end
        m_dat = 1'b1;
        cyc(2 * H);
    endtask

    task automatic host_rx(output logic [7:0] data, output logic par, output logic stop,
                           output logic ok);
        logic [9:0] bits;
        int         t;
        t = 0;
        bits = 10'd0;
        while (!(dat_oe && !clk_oe) && t < 3000) begin
            cyc(1);
            t++;
        end
        ok = (dat_oe && !clk_oe);
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                cyc(H);
                m_clk = 1'b0;
                cyc(H);
                bits[i] = ps2_dat;
                m_clk = 1'b1;
            end
            cyc(H / 2);
            m_dat = 1'b0;
            cyc(H);
            m_clk = 1'b0;
            cyc(H);
            m_clk = 1'b1;
            m_dat = 1'b1;
            cyc(2 * H);
        end
        data = bits[7:0];
        par  = bits[8];
        stop = bits[9];
    endtask

    task automatic init_seq(input string tag, input logic [7:0] reply);
        logic [7:0] d;
        logic       p, s, ok;
        host_rx(d, p, s, ok);
        chk({tag, "/req"}, ok, 1);
        chk({tag, "/cmd"}, d, 8'hF4);
        chk({tag, "/par"}, p, 0);
        chk({tag, "/stop"}, s, 1);
        cyc(H);
        send_byte(reply, 1'b0);
    endtask

    task automatic pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input int ex, input int ey, input int eb);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        chk({tag, "/valid"}, n_valid - v0, 1);
        chk({tag, "/err"}, n_err - e0, 0);
        chk({tag, "/x"}, x, ex);
        chk({tag, "/y"}, y, ey);
        chk({tag, "/btn"}, btn, eb);
    endtask

    initial begin
        int hi, t, v0, e0;

        cyc(3);
        chk("rst/x", x, 319);
        chk("rst/y", y, 239);
        chk("rst/btn", btn, 0);
        chk("rst/valid", vld, 0);
        chk("rst/init", init_done, 0);
        chk("rst/err", err, 0);
        chk("rst/clk_oe", clk_oe, 0);
        chk("rst/dat_oe", dat_oe, 0);
        rst_n = 1'b1;

        hi = 0;
        t  = 0;
        while (t < 500 && !(hi > 0 && !clk_oe)) begin
            cyc(1);
            t++;
            if (clk_oe) hi++;
        end
        checks++;
        assert (hi >= 48 && hi <= 52) else begin
            failures++;
            $error("FAIL inhibit_len: observed=%0d expected=50+-2", hi);
        end
        chk("start_bit/dat_oe", dat_oe, 1);

        init_seq("init", 8'hFA);
        chk("init/done", init_done, 1);
        chk("init/no_err", n_err, 0);

        pkt("p1", 8'h09, 8'h05, 8'h03, 324, 236, 1);
        pkt("p2", 8'h38, 8'h01, 8'h5C, 69, 400, 0);
        pkt("p3", 8'h18, 8'hC0, 8'h00, 5, 400, 0);
        pkt("p4", 8'h38, 8'hF6, 8'h00, 0, 479, 0);
        pkt("x0_minus1", 8'h18, 8'hFF, 8'h00, 0, 479, 0);
        pkt("x_ovf", 8'h48, 8'h10, 8'h10, 0, 463, 0);
        pkt("p7", 8'h08, 8'hFF, 8'hFF, 255, 208, 0);
        pkt("y_clamp0", 8'h08, 8'hFF, 8'hFF, 510, 0, 0);
        pkt("x_clamp639", 8'h08, 8'hFF, 8'hFF, 639, 0, 0);

        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h08, 1'b0);
        send_byte(8'h05, 1'b1);
        chk("par_err/err", n_err - e0, 1);
        chk("par_err/valid", n_valid - v0, 0);
        pkt("after_par", 8'h1C, 8'hF6, 8'h00, 629, 0, 4);

        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h00, 1'b0);
        chk("stray/err", n_err - e0, 0);
        chk("stray/valid", n_valid - v0, 0);
        pkt("after_stray", 8'h2A, 8'h00, 8'hF6, 629, 10, 2);

        send_byte(8'h09, 1'b0);
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("midrst/x", x, 319);
        chk("midrst/y", y, 239);
        chk("midrst/btn", btn, 0);
        chk("midrst/init", init_done, 0);
        cyc(3);
        rst_n = 1'b1;

        e0 = n_err;
        init_seq("nack", 8'hFE);
        chk("nack/err", n_err - e0, 1);
        chk("nack/init", init_done, 0);
        init_seq("retry", 8'hFA);
        chk("retry/init", init_done, 1);

        cyc(2);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        e0 = n_err;
        t  = 0;
        while (n_err == e0 && t < 15000) begin
            cyc(1);
            t++;
        end
        chk("tx_to/err", n_err - e0, 1);
        checks++;
        assert (t >= 10000 && t <= 10100) else begin
            failures++;
            $error("FAIL tx_to/latency: observed=%0d expected=10000..10100", t);
        end
        cyc(3);
        chk("tx_to/inhibit", clk_oe, 1);
        chk("tx_to/init", init_done, 0);
        init_seq("tx_to_retry", 8'hFA);
        chk("tx_to_retry/init", init_done, 1);

        chk("no_overlap", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_cursor.md
# ps2_mouse_cursor

PS/2 mouse front end for the paint datapath. It enables streaming on a standard PS/2 mouse by sending command 0xF4. It then receives 3-byte movement packets and accumulates a clamped cursor position plus button state. The outputs are presented to the processor as memory-mapped inputs; the processor then writes index data into the vga_controller. One instance sits on PS2_CLK/PS2_DAT; the top level drives each pad as `oe ? 1'b0 : 1'bz`.

## Interface
- CLK_HZ, 50_000_000: iCLK frequency; all µs/ms delays derive from it.
- X_MAX, 639: maximum cursor X; range 0..X_MAX.
- Y_MAX, 479: maximum cursor Y; range 0..Y_MAX.
- FILT, 8: cycles a synchronised PS/2 line must be stable before its filtered value changes.

- iCLK  in  1  system clock (CLOCK_50); one clock; reset is asynchronous and active-low.
- iRST_n  in  1  asynchronous active-low reset.
- iPS2_CLK  in  1  raw PS2_CLK pad value.
- iPS2_DAT  in  1  raw PS2_DAT pad value.
- oPS2_CLK_OE  out  1  1 = pull PS2_CLK low.
- oPS2_DAT_OE  out  1  1 = pull PS2_DAT low.
- oX  out  10  cursor X.
- oY  out  9  cursor Y, top = 0.
- oBTN  out  3  {middle, right, left}, 1 = pressed.
- oVALID  out  1  one-cycle pulse: packet applied to oX/oY/oBTN.
- oINIT_DONE  out  1  0xF4 acknowledged; stream mode active.
- oERR  out  1  one-cycle pulse on parity, framing, timeout or NACK error.

## Operation
- Input conditioning:
  - Each PS/2 input passes through a 2-flop synchroniser, then the FILT stability filter.
  - A device clock edge is a filtered 1→0 transition (fall).
- Reset values: oX=X_MAX/2 (319), oY=Y_MAX/2 (239), oBTN=0, oVALID=0, oINIT_DONE=0, oERR=0, both OE=0. State = INHIBIT.
- FSM states:
  - INHIBIT: CLK_OE=1 for 100 µs, then go to REQ.
  - REQ: DAT_OE=1 (start bit). CLK_OE=0 one cycle later. Go to TX.
  - TX: on each fall, drive the next bit: data[0..7] LSB first, then odd parity, then stop. The stop bit releases DAT_OE. After the 10th fall, go to TX_ACK.
  - TX_ACK: on the next fall, the filtered data must be 0. If it is, go to WAIT_FA; otherwise pulse oERR and go to INHIBIT.
  - WAIT_FA: receive one byte. 0xFA → oINIT_DONE=1, go to STREAM. Any other byte → pulse oERR, go to INHIBIT.
  - STREAM: receive bytes indefinitely.
- Receive framing, 11 bits sampled at falls:
  - Start bit must be 0.
  - 8 data bits.
  - Parity: the count of ones over data plus parity must be odd.
  - Stop bit must be 1.
  - Any violation pulses oERR, discards the byte and resets the packet byte index to 0.
- Watchdogs:
  - No fall for 2 ms in the middle of a frame: abort the frame, pulse oERR, reset the byte index.
  - No fall for 20 ms in TX or TX_ACK: pulse oERR, go to INHIBIT.
- Packet assembly in STREAM:
  - Byte index 0 is accepted only if bit3=1; otherwise the byte is dropped and the index stays 0 (resync).
  - Byte 0 fields: [0] left, [1] right, [2] middle, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
  - dx = {Xsign, byte1} and dy = {Ysign, byte2}, both 9-bit two's complement (−256..255).
- Cursor update, on the third byte:
  - oBTN is always updated.
  - X: nx = oX + dx in 11-bit signed; clamp to 0..X_MAX. Skip this axis if X overflow is set.
  - Y: ny = oY − dy, because mouse +Y is up; clamp to 0..Y_MAX. Skip this axis if Y overflow is set.
  - oVALID pulses.
- In STREAM, the block never transmits; OE outputs stay 0.

## Timing
- Stop-bit fall detected in cycle N (filtered):
  - byte available internally at N+1;
  - third-byte registers (oX/oY/oBTN) update and oVALID=1 during N+2.
- oVALID and oERR are exactly one cycle wide, and never assert in the same cycle.
- A TX bit changes the cycle after the fall is detected, which is well inside the device's ~40 µs low phase.
- Filter latency is 2+FILT cycles from pad to filtered value.
- Reset asserted mid-frame or mid-TX: all outputs return to reset values immediately (asynchronous). After release, the block restarts at INHIBIT.
- Clamp boundaries:
  - oX=0 with dx=−1 stays 0.
  - oX=639 with dx=+255 gives 639.
  - oY=0 with a positive dy (mouse up) stays 0.

## Test plan
- Init: release reset with a bench mouse model. Expect CLK_OE low for 5000±2 cycles, then start bit, then transmitted bits 0xF4 with parity 0. Model acks and sends 0xFA → oINIT_DONE=1, oERR never pulses.
- Packet 0x09,0x05,0x03 → oVALID once, oBTN=3'b001, oX=324, oY=236.
- Packet 0x38,0xF6,0x00 (dx=−10, dy=−256) at oX=5, oY=400 → oX=0, oY=479; packet 0x48,0x10,0x10 → oX=0 (X overflow, X unchanged), oY=463.
- Parity error on byte 1 → oERR pulse, no oVALID. Next valid 3-byte packet applies normally. Stray byte 0x00 at index 0 is dropped silently.
- Model sends 0xFE instead of 0xFA → oERR, retransmission of 0xF4 starting from INHIBIT. Model never clocks in TX → oERR after 1,000,000 cycles, then retry.
- iRST_n pulsed low mid-packet (after byte 1) → oX=319, oY=239, oINIT_DONE=0, and the full init sequence repeats.
